nanov_alu_seq: RTL and testbench

- Sequencer for the team's bit-serial ALU slice `nanoV_alu`.
- Accepts a 32-bit operand pair and a 4-bit op over a valid/ready handshake.
- Shifts the operands LSB-first through one internally instantiated `nanoV_alu` over WIDTH cycles and manages the carry/borrow chain.
- Resolves SLT/SLTU on the final bit, then presents a registered WIDTH-bit result with backpressure. Used for multi-cycle ALU offload and as a standalone check of the serial datapath.

---
 rtl/nanov_alu_seq.sv | 173 +++++++++++++++++
 tb/tb_nanov_alu_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nanov_alu_seq.sv
// nanov_alu_seq: sequencer that runs a WIDTH-bit operand pair LSB-first
// through the bit-serial ALU slice nanoV_alu, one bit per clock.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (req_ready = state is IDLE)
//   req_op, req_a, req_b op code and operands, sampled on the accept edge
//   flush                synchronous abort, returns to IDLE
//   res_valid/res_ready  result handshake (res_valid = state is DONE)
//   res_d, res_err       registered result, illegal-op flag
//   busy                 state is not IDLE
//
// nanoV_alu: one-bit ALU slice.
//   op      ALU op code
//   a, b    operand bits
//   cy_in   carry/borrow in
//   d       result bit
//   cy_out  carry/borrow out
//   lts     signed less-than, meaningful on the sign bit

module nanoV_alu (
  input  logic [3:0] op,
  input  logic       a,
  input  logic       b,
  input  logic       cy_in,
  output logic       d,
  output logic       cy_out,
  output logic       lts
);

  logic       b_in;
  logic [1:0] sum;

  always_comb begin
    // SUB/SLT/SLTU add the inverted B; the +1 comes in through cy_in.
    b_in   = (op[1] | op[3]) ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_in} + {1'b0, cy_in};
    cy_out = sum[1];
    // Different signs: A is lower iff A is negative. Same signs: sign of A-B.
    lts    = (a ^ b) ? a : sum[0];
    case (op[2:0])
      3'b000:  d = sum[0];
      3'b111:  d = a & b;
      3'b110:  d = a | b;
      3'b100:  d = a ^ b;
      default: d = 1'b0;
    endcase
  end

endmodule

module nanov_alu_seq #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_d,
  output logic             res_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             err_q;

  logic             slice_d, slice_cy, slice_lts;
  logic             last_bit;
  logic             req_illegal;

  nanoV_alu u_slice (
    .op     (op_q),
    .a      (a_q[0]),
    .b      (b_q[0]),
    .cy_in  (carry_q),
    .d      (slice_d),
    .cy_out (slice_cy),
    .lts    (slice_lts)
  );

  always_comb begin
    case (req_op)
      4'b0000, 4'b1000, 4'b0010, 4'b0011,
      4'b0111, 4'b0110, 4'b0100: req_illegal = 1'b0;
      default:                   req_illegal = 1'b1;
    endcase
  end

  assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            a_q     <= req_a;
            b_q     <= req_b;
            cnt_q   <= '0;
            carry_q <= req_op[1] | req_op[3];
            err_q   <= req_illegal;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= slice_cy;
          cnt_q   <= cnt_q + CW'(1);
          // On the sign bit the compare ops replace the (all-zero) shifted
          // result with their single answer bit.
          if (last_bit && err_q)
            res_q <= '0;
          else if (last_bit && op_q == OP_SLT)
            res_q <= {{(WIDTH-1){1'b0}}, slice_lts};
          else if (last_bit && op_q == OP_SLTU)
            res_q <= {{(WIDTH-1){1'b0}}, ~slice_cy};
          else
            res_q <= {slice_d, res_q[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_d     = res_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_nanov_alu_seq.sv
module tb_nanov_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [W-1:0] req_a, req_b;
  logic         flush;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_d;
  logic         res_err;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         err;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  nanov_alu_seq #(.WIDTH(W), .CW(6)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_d     (res_d),
    .res_err   (res_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0010: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'b0011: return (a < b) ? W'(1) : W'(0);
      4'b0111: return a & b;
      4'b0110: return a | b;
      4'b0100: return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Present a request in IDLE for one edge; scramble the inputs afterwards
  // so a design that samples late produces a wrong answer.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] d, input logic err, input bit push);
    exp_t e;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_a     = ~a;
    req_b     = a ^ b;
    req_op    = ~op;
    check("accept_busy", W'(busy), W'(1));
    if (push) begin
      e.d   = d;
      e.err = err;
      sb.push_back(e);
    end
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!res_valid && n < W + 8) begin
      step();
      n++;
    end
    if (!res_valid) check("res_valid_timeout", W'(res_valid), W'(1));
  endtask

  task automatic compare_result(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, W'(0), W'(1));
    end else begin
      e = sb.pop_front();
      check({name, "_d"}, res_d, e.d);
      check({name, "_err"}, W'(res_err), W'(e.err));
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("after_consume_valid", W'(res_valid), W'(0));
    check("after_consume_ready", W'(req_ready), W'(1));
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] d, input logic err);
    int n;
    send(op, a, b, d, err, 1'b1);
    wait_result(n);
    check({name, "_latency"}, W'(n), W'(W));
    compare_result(name);
    consume();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_ready"}, W'(req_ready), W'(1));
    check({name, "_res_valid"}, W'(res_valid), W'(0));
    check({name, "_res_d"},     res_d,         W'(0));
    check({name, "_res_err"},   W'(res_err),   W'(0));
    check({name, "_busy"},      W'(busy),      W'(0));
  endtask

  initial begin
    int n;
    logic [W-1:0] held;
    logic [3:0]   legal_ops [7];

    legal_ops = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111, 4'b0110, 4'b0100};

    vecs[0]  = '{4'b0000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0};
    vecs[1]  = '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[2]  = '{4'b1000, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[4]  = '{4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[5]  = '{4'b0011, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[6]  = '{4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0};
    vecs[7]  = '{4'b0111, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0};
    vecs[8]  = '{4'b0110, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0};
    vecs[9]  = '{4'b0100, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0};
    vecs[10] = '{4'b0001, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0000_0000, 1'b1};
    vecs[11] = '{4'b0010, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

    rstn      = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    flush     = 1'b0;
    res_ready = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    #2 rstn = 1'b1;
    step();

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].err);

    for (int k = 0; k < 8; k++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      op = legal_ops[$urandom_range(0, 6)];
      a  = W'($urandom);
      b  = W'($urandom);
      if (k == 0) b = a;
      run_op($sformatf("rand%0d", k), op, a, b, ref_alu(op, a, b), 1'b0);
    end

    // Backpressure: result must hold for 10 cycles while res_ready is low.
    send(4'b0000, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b1);
    wait_result(n);
    check("bp_latency", W'(n), W'(W));
    held = res_d;
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", W'(res_valid), W'(1));
      check("bp_d_stable", res_d, held);
      check("bp_req_ready", W'(req_ready), W'(0));
      step();
    end
    compare_result("bp");
    consume();
    check("bp_idle_busy", W'(busy), W'(0));
    send(4'b1000, 32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b0, 1'b1);
    wait_result(n);
    check("b2b_latency", W'(n), W'(W));
    compare_result("b2b");
    consume();

    // Flush at counter 10 of an ADD whose carry chain is live.
    send(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, '0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", W'(busy), W'(0));
    check("flush_ready", W'(req_ready), W'(1));
    n = 0;
    for (int c = 0; c < W + 4; c++) begin
      if (res_valid) n++;
      step();
    end
    check("flush_no_valid", W'(n), W'(0));
    req_valid = 1'b1;
    req_op    = 4'b0000;
    flush     = 1'b1;
    step();
    req_valid = 1'b0;
    flush     = 1'b0;
    check("flush_blocks_accept", W'(busy), W'(0));
    run_op("after_flush", 4'b0000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0);

    // Flush in DONE overrides the pending result.
    send(4'b0110, 32'hAAAA_0000, 32'h0000_5555, '0, 1'b0, 1'b0);
    wait_result(n);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_done_valid", W'(res_valid), W'(0));

    // Asynchronous reset mid-RUN: partial ones are in the result register.
    send(4'b0110, 32'hFFFF_FFFF, 32'h0000_0000, '0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) step();
    #2 rstn = 1'b0;
    #1;
    check_reset_outputs("rst_run");
    #1 rstn = 1'b1;
    step();

    // Asynchronous reset mid-DONE.
    send(4'b0110, 32'hFFFF_FFFF, 32'h0000_0000, '0, 1'b0, 1'b0);
    wait_result(n);
    check("rst_done_pre_valid", W'(res_valid), W'(1));
    #2 rstn = 1'b0;
    #1;
    check_reset_outputs("rst_done");
    #1 rstn = 1'b1;
    step();
    run_op("after_reset", 4'b1000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);

    check("sb_drained", W'(sb.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
